// File: rtl/fetch_unit_if.sv
// Fetch unit interface: instruction-memory request/response, redirect
// inputs from execute, and the IF/ID entry handshake toward decode.
interface fetch_unit_if #(
   parameter int unsigned IMEM_ADDR_WIDTH = 11
);
   logic [IMEM_ADDR_WIDTH-1:0] o_imem_addr;
   logic                       o_imem_en;
   logic [31:0]                i_imem_rdata;
   logic                       i_redirect;
   logic [63:0]                i_redirect_pc;
   logic                       o_valid;
   logic                       i_ready;
   logic [31:0]                o_instr;
   logic [63:0]                o_pc;
   logic [63:0]                o_npc;
   logic                       o_exc_misaligned;

   // Fetch unit side.
   modport master (
      output o_imem_addr, o_imem_en, o_valid, o_instr, o_pc, o_npc, o_exc_misaligned,
      input  i_imem_rdata, i_redirect, i_redirect_pc, i_ready
   );

   // Memory / execute / decode side.
   modport slave (
      input  o_imem_addr, o_imem_en, o_valid, o_instr, o_pc, o_npc, o_exc_misaligned,
      output i_imem_rdata, i_redirect, i_redirect_pc, i_ready
   );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: sequential PC generation, 1-cycle synchronous
// instruction memory, 1-entry skid buffer under decode back-pressure,
// redirect flush, and misaligned-target exception delivery.
module fetch_unit #(
   parameter int unsigned IMEM_ADDR_WIDTH = 11,
   parameter logic [63:0] RESET_PC        = 64'h0
) (
   input  logic clk,
   input  logic rst,
   fetch_unit_if.master bus
);

   typedef enum logic [1:0] {RUN, EXC, HALT} state_e;

   state_e      state_q, state_d;
   logic [63:0] fetch_pc_q, fetch_pc_d;
   logic        infl_v_q, infl_v_d;
   logic [63:0] infl_pc_q, infl_pc_d;
   logic        skid_v_q, skid_v_d;
   logic [63:0] skid_pc_q, skid_pc_d;
   logic [31:0] skid_instr_q, skid_instr_d;
   logic        out_v_q, out_v_d;
   logic [63:0] out_pc_q, out_pc_d;
   logic [63:0] out_npc_q, out_npc_d;
   logic [31:0] out_instr_q, out_instr_d;
   logic        out_exc_q, out_exc_d;
   logic        imem_en;
   logic        out_free;

   assign bus.o_imem_addr      = fetch_pc_q[IMEM_ADDR_WIDTH+1:2];
   assign bus.o_imem_en        = imem_en & ~rst;
   assign bus.o_valid          = out_v_q;
   assign bus.o_instr          = out_instr_q;
   assign bus.o_pc             = out_pc_q;
   assign bus.o_npc            = out_npc_q;
   assign bus.o_exc_misaligned = out_exc_q;

   // Next-state: FSM, redirect flush, response steering and fetch issue.
   always_comb begin
      state_d      = state_q;
      fetch_pc_d   = fetch_pc_q;
      infl_v_d     = infl_v_q;
      infl_pc_d    = infl_pc_q;
      skid_v_d     = skid_v_q;
      skid_pc_d    = skid_pc_q;
      skid_instr_d = skid_instr_q;
      out_v_d      = out_v_q;
      out_pc_d     = out_pc_q;
      out_npc_d    = out_npc_q;
      out_instr_d  = out_instr_q;
      out_exc_d    = out_exc_q;
      imem_en      = 1'b0;
      out_free     = ~out_v_q | bus.i_ready;

      if (bus.i_redirect) begin
         infl_v_d   = 1'b0;
         skid_v_d   = 1'b0;
         fetch_pc_d = bus.i_redirect_pc;
         if (bus.i_redirect_pc[1:0] != 2'b00) begin
            state_d     = EXC;
            out_v_d     = 1'b1;
            out_exc_d   = 1'b1;
            out_pc_d    = bus.i_redirect_pc;
            out_npc_d   = bus.i_redirect_pc + 64'd4;
            out_instr_d = 32'h0000_0013;
         end else begin
            state_d   = RUN;
            out_v_d   = 1'b0;
            out_exc_d = 1'b0;
         end
      end else begin
         case (state_q)
            RUN: begin
               // Skid entry is always older than any in-flight word, and the
               // two never coexist because issue is gated below.
               if (skid_v_q) begin
                  if (out_free) begin
                     out_v_d     = 1'b1;
                     out_exc_d   = 1'b0;
                     out_pc_d    = skid_pc_q;
                     out_npc_d   = skid_pc_q + 64'd4;
                     out_instr_d = skid_instr_q;
                     skid_v_d    = 1'b0;
                  end
               end else if (infl_v_q) begin
                  if (out_free) begin
                     out_v_d     = 1'b1;
                     out_exc_d   = 1'b0;
                     out_pc_d    = infl_pc_q;
                     out_npc_d   = infl_pc_q + 64'd4;
                     out_instr_d = bus.i_imem_rdata;
                  end else begin
                     skid_v_d     = 1'b1;
                     skid_pc_d    = infl_pc_q;
                     skid_instr_d = bus.i_imem_rdata;
                  end
               end else if (out_free) begin
                  out_v_d = 1'b0;
               end
               infl_v_d = 1'b0;
               // Issue only when the returning word is guaranteed a slot:
               // skid empty and not about to be filled by this cycle's response.
               if (!skid_v_q && !(infl_v_q && !out_free)) begin
                  imem_en    = 1'b1;
                  infl_v_d   = 1'b1;
                  infl_pc_d  = fetch_pc_q;
                  fetch_pc_d = fetch_pc_q + 64'd4;
               end
            end
            EXC: begin
               if (bus.i_ready) begin
                  out_v_d = 1'b0;
                  state_d = HALT;
               end
            end
            HALT: ;
            default: state_d = RUN;
         endcase
      end
   end

   // State register with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= RUN;
         fetch_pc_q   <= RESET_PC;
         infl_v_q     <= 1'b0;
         infl_pc_q    <= '0;
         skid_v_q     <= 1'b0;
         skid_pc_q    <= '0;
         skid_instr_q <= '0;
         out_v_q      <= 1'b0;
         out_pc_q     <= '0;
         out_npc_q    <= '0;
         out_instr_q  <= '0;
         out_exc_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         fetch_pc_q   <= fetch_pc_d;
         infl_v_q     <= infl_v_d;
         infl_pc_q    <= infl_pc_d;
         skid_v_q     <= skid_v_d;
         skid_pc_q    <= skid_pc_d;
         skid_instr_q <= skid_instr_d;
         out_v_q      <= out_v_d;
         out_pc_q     <= out_pc_d;
         out_npc_q    <= out_npc_d;
         out_instr_q  <= out_instr_d;
         out_exc_q    <= out_exc_d;
      end
   end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed testbench for fetch_unit: memory word n holds the value n.
module tb_fetch_unit;

   logic clk = 1'b0;
   logic rst;
   int unsigned checks = 0;
   int unsigned errors = 0;

   always #5 clk = ~clk;

   fetch_unit_if #(.IMEM_ADDR_WIDTH(11)) bus ();

   fetch_unit #(.IMEM_ADDR_WIDTH(11), .RESET_PC(64'h0)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.master)
   );

   // Synchronous instruction memory: word n = n, one cycle latency.
   always @(posedge clk) begin
      if (bus.o_imem_en) bus.i_imem_rdata <= {21'b0, bus.o_imem_addr};
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic nxt();
      @(negedge clk);
      #1;
   endtask

   function automatic logic [63:0] word_of(input logic [63:0] pc);
      return {53'b0, pc[12:2]};
   endfunction

   // Check one normal entry (waiting a bounded number of cycles for it).
   task automatic expect_entry(input string tag, input logic [63:0] pc);
      int unsigned n = 0;
      while (!bus.o_valid && n < 8) begin
         nxt();
         n++;
      end
      check({tag, "_valid"}, {63'b0, bus.o_valid}, 64'd1);
      check({tag, "_pc"}, bus.o_pc, pc);
      check({tag, "_instr"}, {32'b0, bus.o_instr}, word_of(pc));
      check({tag, "_npc"}, bus.o_npc, pc + 64'd4);
      check({tag, "_exc"}, {63'b0, bus.o_exc_misaligned}, 64'd0);
      nxt();
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst               = 1'b1;
      bus.i_ready       = 1'b1;
      bus.i_redirect    = 1'b0;
      bus.i_redirect_pc = 64'h0;
      repeat (3) nxt();
      check("rst_valid", {63'b0, bus.o_valid}, 64'd0);
      check("rst_pc", bus.o_pc, 64'd0);
      check("rst_instr", {32'b0, bus.o_instr}, 64'd0);
      check("rst_npc", bus.o_npc, 64'd0);
      check("rst_exc", {63'b0, bus.o_exc_misaligned}, 64'd0);
      check("rst_en", {63'b0, bus.o_imem_en}, 64'd0);

      // Reset release: request to RESET_PC, first entry two cycles later.
      rst = 1'b0;
      #1;
      check("rel_en", {63'b0, bus.o_imem_en}, 64'd1);
      check("rel_addr", {53'b0, bus.o_imem_addr}, 64'd0);
      nxt();
      check("lat_valid", {63'b0, bus.o_valid}, 64'd0);
      for (int i = 0; i < 6; i++) begin
         nxt();
         check("seq_valid", {63'b0, bus.o_valid}, 64'd1);
         check("seq_pc", bus.o_pc, 64'(4 * i));
         check("seq_instr", {32'b0, bus.o_instr}, 64'(i));
         check("seq_npc", bus.o_npc, 64'(4 * i + 4));
      end

      // Back-pressure for 5 cycles: entry at pc 24 holds, fetch stops.
      nxt();
      bus.i_ready = 1'b0;
      #1;
      for (int i = 0; i < 5; i++) begin
         nxt();
         check("stall_valid", {63'b0, bus.o_valid}, 64'd1);
         check("stall_pc", bus.o_pc, 64'd24);
         check("stall_instr", {32'b0, bus.o_instr}, 64'd6);
         check("stall_en", {63'b0, bus.o_imem_en}, 64'd0);
      end
      bus.i_ready = 1'b1;
      for (int i = 0; i < 5; i++) expect_entry("resume", 64'(24 + 4 * i));

      // Aligned redirect while stalled: stalled entry discarded.
      bus.i_ready       = 1'b0;
      bus.i_redirect    = 1'b1;
      bus.i_redirect_pc = 64'h100;
      nxt();
      bus.i_redirect = 1'b0;
      bus.i_ready    = 1'b1;
      check("rd_t1_valid", {63'b0, bus.o_valid}, 64'd0);
      nxt();
      check("rd_t2_valid", {63'b0, bus.o_valid}, 64'd0);
      nxt();
      check("rd_t3_valid", {63'b0, bus.o_valid}, 64'd1);
      check("rd_t3_pc", bus.o_pc, 64'h100);
      check("rd_t3_instr", {32'b0, bus.o_instr}, 64'h40);
      nxt();
      check("rd_t4_pc", bus.o_pc, 64'h104);
      check("rd_t4_instr", {32'b0, bus.o_instr}, 64'h41);
      nxt();

      // Misaligned redirect: single exception entry, then halt.
      bus.i_ready       = 1'b0;
      bus.i_redirect    = 1'b1;
      bus.i_redirect_pc = 64'h102;
      nxt();
      bus.i_redirect = 1'b0;
      #1;
      check("exc_valid", {63'b0, bus.o_valid}, 64'd1);
      check("exc_flag", {63'b0, bus.o_exc_misaligned}, 64'd1);
      check("exc_pc", bus.o_pc, 64'h102);
      check("exc_npc", bus.o_npc, 64'h106);
      check("exc_instr", {32'b0, bus.o_instr}, 64'h13);
      check("exc_en", {63'b0, bus.o_imem_en}, 64'd0);
      nxt();
      check("exc_hold_pc", bus.o_pc, 64'h102);
      check("exc_hold_valid", {63'b0, bus.o_valid}, 64'd1);
      bus.i_ready = 1'b1;
      nxt();
      check("halt_valid", {63'b0, bus.o_valid}, 64'd0);
      check("halt_en", {63'b0, bus.o_imem_en}, 64'd0);
      nxt();
      check("halt2_valid", {63'b0, bus.o_valid}, 64'd0);
      check("halt2_en", {63'b0, bus.o_imem_en}, 64'd0);
      bus.i_redirect    = 1'b1;
      bus.i_redirect_pc = 64'h200;
      nxt();
      bus.i_redirect = 1'b0;
      #1;
      check("wake_valid", {63'b0, bus.o_valid}, 64'd0);
      check("wake_en", {63'b0, bus.o_imem_en}, 64'd1);
      check("wake_addr", {53'b0, bus.o_imem_addr}, 64'h80);
      nxt();
      check("wake_t2_valid", {63'b0, bus.o_valid}, 64'd0);
      nxt();
      check("wake_t3_valid", {63'b0, bus.o_valid}, 64'd1);
      check("wake_t3_pc", bus.o_pc, 64'h200);
      check("wake_t3_instr", {32'b0, bus.o_instr}, 64'h80);
      check("wake_t3_exc", {63'b0, bus.o_exc_misaligned}, 64'd0);
      nxt();
      check("wake_t4_pc", bus.o_pc, 64'h204);

      // 64-bit wrap of sequential fetch.
      bus.i_redirect    = 1'b1;
      bus.i_redirect_pc = 64'hFFFF_FFFF_FFFF_FFF8;
      nxt();
      bus.i_redirect = 1'b0;
      nxt();
      nxt();
      check("wrap0_pc", bus.o_pc, 64'hFFFF_FFFF_FFFF_FFF8);
      check("wrap0_instr", {32'b0, bus.o_instr}, 64'h7FE);
      nxt();
      check("wrap1_pc", bus.o_pc, 64'hFFFF_FFFF_FFFF_FFFC);
      check("wrap1_instr", {32'b0, bus.o_instr}, 64'h7FF);
      check("wrap1_npc", bus.o_npc, 64'h0);
      nxt();
      check("wrap2_valid", {63'b0, bus.o_valid}, 64'd1);
      check("wrap2_pc", bus.o_pc, 64'h0);
      check("wrap2_instr", {32'b0, bus.o_instr}, 64'h0);
      nxt();

      // Reset while stalled with a full skid buffer; rst beats redirect.
      bus.i_ready = 1'b0;
      nxt();
      check("fill_pc", bus.o_pc, 64'h4);
      check("fill_en", {63'b0, bus.o_imem_en}, 64'd0);
      nxt();
      check("full_pc", bus.o_pc, 64'h4);
      check("full_en", {63'b0, bus.o_imem_en}, 64'd0);
      rst               = 1'b1;
      bus.i_redirect    = 1'b1;
      bus.i_redirect_pc = 64'h500;
      nxt();
      check("mrst_valid", {63'b0, bus.o_valid}, 64'd0);
      check("mrst_pc", bus.o_pc, 64'd0);
      check("mrst_instr", {32'b0, bus.o_instr}, 64'd0);
      check("mrst_npc", bus.o_npc, 64'd0);
      check("mrst_exc", {63'b0, bus.o_exc_misaligned}, 64'd0);
      check("mrst_en", {63'b0, bus.o_imem_en}, 64'd0);
      rst            = 1'b0;
      bus.i_redirect = 1'b0;
      bus.i_ready    = 1'b1;
      #1;
      check("mrel_en", {63'b0, bus.o_imem_en}, 64'd1);
      check("mrel_addr", {53'b0, bus.o_imem_addr}, 64'd0);
      nxt();
      check("mrel_lat_valid", {63'b0, bus.o_valid}, 64'd0);
      nxt();
      check("mrel_valid", {63'b0, bus.o_valid}, 64'd1);
      check("mrel_pc", bus.o_pc, 64'd0);
      check("mrel_instr", {32'b0, bus.o_instr}, 64'd0);
      nxt();
      check("mrel2_pc", bus.o_pc, 64'd4);
      check("mrel2_instr", {32'b0, bus.o_instr}, 64'd1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter IMEM_ADDR_WIDTH, default 11, meaning the instruction memory word-address width.
REQ-002 SHALL have parameter RESET_PC, default 64'h0, meaning the first fetch address after reset.
REQ-003 clk  input  1  the single clock; all state updates on the rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 o_imem_addr  output  IMEM_ADDR_WIDTH  word address presented to the synchronous instruction memory; equals fetch_pc[IMEM_ADDR_WIDTH+1:2].
REQ-006 o_imem_en  output  1  high when the presented address is a real fetch request.
REQ-007 i_imem_rdata  input  32  instruction word, valid one cycle after the request.
REQ-008 i_redirect  input  1  branch/jump redirect strobe from execute.
REQ-009 i_redirect_pc  input  64  redirect target.
REQ-010 o_valid  output  1  IF/ID entry valid.
REQ-011 i_ready  input  1  decode accepts the entry this cycle.
REQ-012 o_instr  output  32  instruction word.
REQ-013 o_pc  output  64  address of o_instr.
REQ-014 o_npc  output  64  o_pc + 4.
REQ-015 o_exc_misaligned  output  1  entry carries an instruction-address-misaligned exception.

Function
REQ-016 SHALL transfer an entry only when o_valid and i_ready are both high; the o_* entry fields SHALL hold stable while o_valid is high and i_ready is low.
REQ-017 SHALL treat memory as always-ready with a fixed 1-cycle read latency; the data for a request issued in cycle t is sampled in cycle t+1.
REQ-018 SHALL contain a 1-entry skid buffer, so that no fetched word is lost or duplicated under back-pressure; fetch_pc SHALL NOT advance while the skid buffer is full.
REQ-019 SHALL deliver entries strictly in program order; sequential fetch_pc SHALL increment by 4 using 64-bit wrap-around arithmetic.
REQ-020 SHALL ignore fetch_pc bits above IMEM_ADDR_WIDTH+1 for addressing; o_pc SHALL carry all 64 bits.
REQ-021 With i_ready held high, SHALL sustain one entry per cycle; the first entry SHALL appear 2 cycles after the request is issued.
REQ-022 SHALL implement the FSM states RUN, EXC, and HALT; RUN is the reset state.
REQ-023 RUN: on i_redirect with i_redirect_pc[1:0]==0, SHALL kill the in-flight response, the skid buffer, and the output entry at the next edge, and issue a request to i_redirect_pc in cycle t+1; o_valid with o_pc=target SHALL be seen at t+3.
REQ-024 RUN: on i_redirect with i_redirect_pc[1:0]!=0, SHALL flush as in REQ-023 and go to EXC, presenting o_valid=1, o_exc_misaligned=1, o_pc=target, o_npc=target+4, o_instr=32'h00000013.
REQ-025 EXC: once that entry is accepted, SHALL go to HALT; in HALT o_imem_en=0 and o_valid=0.
REQ-026 EXC/HALT: an aligned i_redirect SHALL return the FSM to RUN per REQ-023; a misaligned i_redirect SHALL re-enter EXC with the new target.
REQ-027 i_redirect SHALL take priority over back-pressure; a redirect while o_valid is high and i_ready is low SHALL still discard the stalled entry.
REQ-028 o_exc_misaligned SHALL be 0 on every RUN-state entry.

Reset
REQ-029 While rst is high: o_valid=0, o_exc_misaligned=0, o_instr=0, o_pc=0, o_npc=0, o_imem_en=0, skid buffer empty, FSM in RUN, fetch_pc=RESET_PC; rst SHALL override i_redirect.
REQ-030 In the first cycle after rst falls, SHALL issue a request to RESET_PC (o_imem_en=1).
REQ-031 Reset asserted mid-operation SHALL discard all in-flight and buffered entries within the same edge.

Verification
REQ-032 Reset release, RESET_PC=0, i_ready=1, memory word n = n -> o_valid from cycle 2 with o_pc=0,4,8,... and o_instr=0,1,2,... on consecutive cycles.
REQ-033 i_ready=0 for 5 cycles mid-stream, then 1 -> entry held stable throughout, then the sequence resumes with no gap in o_pc and no duplicate.
REQ-034 i_redirect with i_redirect_pc=0x100 at cycle t -> o_valid=0 at t+1 and t+2, o_pc=0x100 at t+3, wrong-path words never presented.
REQ-035 i_redirect_pc=0x102 -> a single entry with o_exc_misaligned=1 and o_pc=0x102, then o_valid=0 and o_imem_en=0; a later redirect to 0x200 -> normal fetch resumes at 0x200.
REQ-036 fetch_pc=64'hFFFF_FFFF_FFFF_FFFC sequential -> next o_pc=0, o_npc of the prior entry = 0.
REQ-037 rst pulsed while stalled with a full skid buffer -> outputs at reset values next cycle, restart at RESET_PC.
